anti_theft_fsm: RTL and testbench
=================================

# anti_theft_fsm

Central controller of the anti-theft system: watches ignition and door sensors and sequences the arm, trigger and alarm behaviour. It sits directly upstream of the countdown timer. It issues a one-cycle start pulse with a 4-bit load value selected from four reprogrammable interval registers, and consumes the timer's sticky expiry flag. It drives the siren and the status LED.

## Interface
- No Verilog parameters; interval defaults are package constants: T_ARM_DELAY=6, T_DRIVER_DELAY=8, T_PASSENGER_DELAY=15, T_ALARM_ON=10 (seconds).
- clk  in  1  single system clock (fast clock, e.g. 25 MHz); the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- ignition  in  1  key switch on; synchronous, debounced.
- door_driver  in  1  driver door open.
- door_pass  in  1  passenger door open.
- reprogram  in  1  single-cycle pulse: write time_value into interval selected by time_sel.
- time_sel  in  2  interval index: 0 arm delay, 1 driver delay, 2 passenger delay, 3 alarm-on.
- time_value  in  4  new interval value, seconds.
- one_hz_enable  in  1  1 Hz single-cycle enable from divider (LED blink only).
- timer_expired  in  1  sticky expiry flag from timer; cleared by timer one cycle after start.
- start_timer  out  1  registered one-cycle pulse loading the timer.
- load_value  out  4  registered interval value; valid with start_timer, held until next start.
- siren  out  1  registered alarm output.
- status_led  out  1  registered status indicator.
- fsm_state  out  3  current state encoding (debug).

## Operation
- States: ARMED, TRIGGERED, ALARM, DIS_IGN, DIS_WAIT_OPEN, DIS_WAIT_CLOSE, ARM_DELAY.
- ARMED: door_driver -> TRIGGERED, start with T_DRIVER_DELAY. Else door_pass -> TRIGGERED, start with T_PASSENGER_DELAY. Driver wins if both open. ignition -> DIS_IGN, and ignition has priority over doors.
- TRIGGERED: ignition -> DIS_IGN. Qualified expiry -> ALARM.
- ALARM: siren=1.
  - ignition -> DIS_IGN.
  - Any door open: stay and hold the siren; a close then restarts the hold.
  - Transition from any door open to all closed: start with T_ALARM_ON. A qualified expiry with all doors closed -> ARMED.
- DIS_IGN: ignition low -> DIS_WAIT_OPEN.
- DIS_WAIT_OPEN: ignition -> DIS_IGN. door_driver -> DIS_WAIT_CLOSE.
- DIS_WAIT_CLOSE: ignition -> DIS_IGN. Both doors closed -> ARM_DELAY, start with T_ARM_DELAY.
- ARM_DELAY: ignition -> DIS_IGN. Any door open -> DIS_WAIT_CLOSE. Qualified expiry -> ARMED.
- Qualified expiry: timer_expired && !start_timer && !start_d1, where start_d1 is start_timer delayed one cycle. This blocks stale expiry from the previous countdown.
- Entering ALARM directly from TRIGGERED: no start pulse until doors all close.
- reprogram: writes interval[time_sel] and forces ARMED next cycle, with no start pulse. Applies in every state, including ALARM, and clears the siren.
  - A running timer is abandoned.
  - Its later expiry is ignored unless a new start issues.
- A value of 0 is legal. The timer expires at the next 1 Hz enable.
- status_led:
  - ARMED: toggles on each one_hz_enable.
  - TRIGGERED, ALARM: 1.
  - All other states: 0.

## Timing
- Reset values:
  - State ARMED.
  - start_timer=0, load_value=0, siren=0, status_led=0, fsm_state=ARMED.
  - Interval registers = package defaults.
- Transitions and all outputs update on the edge after the causing input is sampled (1-cycle latency).
- start_timer is high for exactly one cycle per transition that requires a start. load_value changes only in that same cycle.
- reprogram write is visible to a start issued in the cycle after the write.
- Simultaneous reprogram and any sensor event: reprogram wins.
- Reset mid-countdown returns to ARMED immediately. The timer is not restarted.

## Configuration
- STATUS_BLINK_EN defined: status_led in ARMED toggles on one_hz_enable.
- STATUS_BLINK_EN undefined: status_led is solid 1 in ARMED. one_hz_enable is unused and its toggle register is omitted.
- TRIGGERED and ALARM LED behaviour is identical either way.

## Structure
- Shared package anti_theft_pkg holds:
  - The state enum, 3-bit encoding.
  - The time_sel index constants.
  - The four default interval constants.
  - The 4-bit interval width constant.
- The package is also used by the timer bench.
- One sub-module: time_param_regs. It holds the four 4-bit registers, the reprogram write port, and the combinational read by index.

## Test plan
- Reset, then door_driver=1 -> start_timer pulse with load_value=8. State TRIGGERED, status_led=1.
- TRIGGERED, timer_expired held from a stale count during the start cycle and the next cycle -> no ALARM. Later fresh expiry -> ALARM with siren=1.
- ALARM with door open, then doors closed -> start with load_value=10. Expiry -> ARMED, siren=0.
- Ignition on, then off, driver door open, then close -> start with load_value=6. Passenger door opens before expiry -> DIS_WAIT_CLOSE, no ARMED.
- reprogram with time_sel=2, time_value=3, then door_pass in ARMED -> load_value=3. reprogram during ALARM -> siren=0 and ARMED next cycle.
- Both doors open in the same cycle in ARMED -> load_value=8. Ignition and door together -> DIS_IGN, no start.

Source files
------------

// File: rtl/anti_theft_pkg.sv
// Shared types and constants for the anti-theft controller and its timer bench.
package anti_theft_pkg;

  localparam int IVL_W = 4;

  typedef enum logic [2:0] {
    ST_ARMED          = 3'd0,
    ST_TRIGGERED      = 3'd1,
    ST_ALARM          = 3'd2,
    ST_DIS_IGN        = 3'd3,
    ST_DIS_WAIT_OPEN  = 3'd4,
    ST_DIS_WAIT_CLOSE = 3'd5,
    ST_ARM_DELAY      = 3'd6
  } state_e;

  localparam logic [1:0] SEL_ARM    = 2'd0;
  localparam logic [1:0] SEL_DRIVER = 2'd1;
  localparam logic [1:0] SEL_PASS   = 2'd2;
  localparam logic [1:0] SEL_ALARM  = 2'd3;

  localparam logic [IVL_W-1:0] T_ARM_DELAY       = 4'd6;
  localparam logic [IVL_W-1:0] T_DRIVER_DELAY    = 4'd8;
  localparam logic [IVL_W-1:0] T_PASSENGER_DELAY = 4'd15;
  localparam logic [IVL_W-1:0] T_ALARM_ON        = 4'd10;

  function automatic logic [IVL_W-1:0] ivl_default(input logic [1:0] sel);
    case (sel)
      SEL_ARM:    return T_ARM_DELAY;
      SEL_DRIVER: return T_DRIVER_DELAY;
      SEL_PASS:   return T_PASSENGER_DELAY;
      default:    return T_ALARM_ON;
    endcase
  endfunction

endpackage

// File: rtl/time_param_regs.sv
// Four reprogrammable interval registers with a single write port and an
// asynchronous read by index; reset restores the package defaults.
module time_param_regs
  import anti_theft_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_sel_i,
  input  logic [IVL_W-1:0] wr_data_i,
  input  logic [1:0]       rd_sel_i,
  output logic [IVL_W-1:0] rd_data_o
);

  logic [IVL_W-1:0] ivl_q [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) ivl_q[i] <= ivl_default(2'(i));
    end else if (wr_en_i) begin
      ivl_q[wr_sel_i] <= wr_data_i;
    end
  end

  assign rd_data_o = ivl_q[rd_sel_i];

endmodule

// File: rtl/anti_theft_fsm.sv
// Anti-theft sequencing controller: arm / trigger / alarm / disarm flow driving
// the countdown timer. Define STATUS_BLINK_EN to blink the LED while armed.
//
// state             | meaning
// ST_ARMED          | armed, waiting for door or ignition
// ST_TRIGGERED      | door opened, entry delay running
// ST_ALARM          | siren on; alarm-on countdown restarts on each door close
// ST_DIS_IGN        | ignition on, disarmed
// ST_DIS_WAIT_OPEN  | ignition off, waiting for driver to open door
// ST_DIS_WAIT_CLOSE | waiting for all doors closed
// ST_ARM_DELAY      | arm delay running before re-arming
module anti_theft_fsm
  import anti_theft_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ignition,
  input  logic             door_driver,
  input  logic             door_pass,
  input  logic             reprogram,
  input  logic [1:0]       time_sel,
  input  logic [IVL_W-1:0] time_value,
  input  logic             one_hz_enable,
  input  logic             timer_expired,
  output logic             start_timer,
  output logic [IVL_W-1:0] load_value,
  output logic             siren,
  output logic             status_led,
  output logic [2:0]       fsm_state
);

  state_e           state_q, state_d;
  logic             start_q, start_d, start_d1_q;
  logic [IVL_W-1:0] load_q, load_d;
  logic             siren_q, siren_d;
  logic             led_q, led_d;
  logic             door_prev_q;
  logic             alarm_run_q, alarm_run_d;
  logic [1:0]       rd_sel_d;
  logic [IVL_W-1:0] ivl_rd;
  logic             any_door, qexp;

  time_param_regs u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (reprogram),
    .wr_sel_i  (time_sel),
    .wr_data_i (time_value),
    .rd_sel_i  (rd_sel_d),
    .rd_data_o (ivl_rd)
  );

  assign any_door = door_driver | door_pass;
  // Expiry during or right after our own start is the previous count's sticky flag.
  assign qexp     = timer_expired & ~start_q & ~start_d1_q;

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    rd_sel_d    = SEL_ARM;
    alarm_run_d = alarm_run_q;
    if (reprogram) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (ignition) state_d = ST_DIS_IGN;
          else if (door_driver) begin
            state_d = ST_TRIGGERED; start_d = 1'b1; rd_sel_d = SEL_DRIVER;
          end else if (door_pass) begin
            state_d = ST_TRIGGERED; start_d = 1'b1; rd_sel_d = SEL_PASS;
          end
        end
        ST_TRIGGERED: begin
          if (ignition) state_d = ST_DIS_IGN;
          else if (qexp) state_d = ST_ALARM;
        end
        ST_ALARM: begin
          // Only an expiry of a count started inside ALARM may end the alarm.
          if (ignition) state_d = ST_DIS_IGN;
          else if (any_door) state_d = ST_ALARM;
          else if (door_prev_q) begin
            start_d = 1'b1; rd_sel_d = SEL_ALARM; alarm_run_d = 1'b1;
          end else if (qexp && alarm_run_q) state_d = ST_ARMED;
        end
        ST_DIS_IGN: begin
          if (!ignition) state_d = ST_DIS_WAIT_OPEN;
        end
        ST_DIS_WAIT_OPEN: begin
          if (ignition) state_d = ST_DIS_IGN;
          else if (door_driver) state_d = ST_DIS_WAIT_CLOSE;
        end
        ST_DIS_WAIT_CLOSE: begin
          if (ignition) state_d = ST_DIS_IGN;
          else if (!any_door) begin
            state_d = ST_ARM_DELAY; start_d = 1'b1; rd_sel_d = SEL_ARM;
          end
        end
        ST_ARM_DELAY: begin
          if (ignition) state_d = ST_DIS_IGN;
          else if (any_door) state_d = ST_DIS_WAIT_CLOSE;
          else if (qexp) state_d = ST_ARMED;
        end
        default: state_d = ST_ARMED;
      endcase
    end
    if (state_d != ST_ALARM) alarm_run_d = 1'b0;

    load_d  = start_d ? ivl_rd : load_q;
    siren_d = (state_d == ST_ALARM);
    if (state_d == ST_TRIGGERED || state_d == ST_ALARM) led_d = 1'b1;
    else if (state_d == ST_ARMED) begin
`ifdef STATUS_BLINK_EN
      led_d = (state_q == ST_ARMED) ? (led_q ^ one_hz_enable) : 1'b0;
`else
      led_d = 1'b1;
`endif
    end else led_d = 1'b0;
  end

`ifndef STATUS_BLINK_EN
  logic unused_one_hz;
  assign unused_one_hz = one_hz_enable;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARMED;
      start_q     <= 1'b0;
      start_d1_q  <= 1'b0;
      load_q      <= '0;
      siren_q     <= 1'b0;
      led_q       <= 1'b0;
      door_prev_q <= 1'b0;
      alarm_run_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      start_d1_q  <= start_q;
      load_q      <= load_d;
      siren_q     <= siren_d;
      led_q       <= led_d;
      door_prev_q <= any_door;
      alarm_run_q <= alarm_run_d;
    end
  end

  assign start_timer = start_q;
  assign load_value  = load_q;
  assign siren       = siren_q;
  assign status_led  = led_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Self-checking bench for anti_theft_fsm: directed vector table, a reset
// mid-countdown sequence, and randomized cycles against a reference model.
module tb_anti_theft_fsm;
  import anti_theft_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ignition, door_driver, door_pass, reprogram, one_hz_enable, timer_expired;
  logic [1:0] time_sel;
  logic [3:0] time_value;
  logic       start_timer, siren, status_led;
  logic [3:0] load_value;
  logic [2:0] fsm_state;

  always #5 clk = ~clk;

  anti_theft_fsm dut (
    .clk(clk), .rst_n(rst_n), .ignition(ignition), .door_driver(door_driver),
    .door_pass(door_pass), .reprogram(reprogram), .time_sel(time_sel),
    .time_value(time_value), .one_hz_enable(one_hz_enable),
    .timer_expired(timer_expired), .start_timer(start_timer),
    .load_value(load_value), .siren(siren), .status_led(status_led),
    .fsm_state(fsm_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expiry counts only from two cycles after the pulse onward.
  state_e     m_state;
  logic       m_start, m_siren, m_led, m_prev_door, m_alarm_counting;
  logic [3:0] m_load;
  logic [3:0] m_ivl [4];
  int         m_since;

  task automatic model_reset();
    m_state = ST_ARMED; m_start = 0; m_load = 0; m_siren = 0; m_led = 0;
    m_since = 100; m_prev_door = 0; m_alarm_counting = 0;
    m_ivl[0] = 4'd6; m_ivl[1] = 4'd8; m_ivl[2] = 4'd15; m_ivl[3] = 4'd10;
  endtask

  task automatic model_step();
    bit any = door_driver | door_pass;
    bit qexp = timer_expired && (m_since >= 2);
    state_e nxt = m_state;
    bit go = 0;
    logic [3:0] v = m_load;
    if (reprogram) begin
      m_ivl[time_sel] = time_value;
      nxt = ST_ARMED;
    end else if (ignition && m_state != ST_DIS_IGN) begin
      nxt = ST_DIS_IGN;
    end else begin
      case (m_state)
        ST_ARMED:
          if (door_driver) begin nxt = ST_TRIGGERED; go = 1; v = m_ivl[1]; end
          else if (door_pass) begin nxt = ST_TRIGGERED; go = 1; v = m_ivl[2]; end
        ST_TRIGGERED: if (qexp) nxt = ST_ALARM;
        ST_ALARM:
          if (!any && m_prev_door) begin go = 1; v = m_ivl[3]; m_alarm_counting = 1; end
          else if (!any && qexp && m_alarm_counting) nxt = ST_ARMED;
        ST_DIS_IGN: if (!ignition) nxt = ST_DIS_WAIT_OPEN;
        ST_DIS_WAIT_OPEN: if (door_driver) nxt = ST_DIS_WAIT_CLOSE;
        ST_DIS_WAIT_CLOSE: if (!any) begin nxt = ST_ARM_DELAY; go = 1; v = m_ivl[0]; end
        ST_ARM_DELAY:
          if (any) nxt = ST_DIS_WAIT_CLOSE;
          else if (qexp) nxt = ST_ARMED;
        default: nxt = ST_ARMED;
      endcase
    end
    if (nxt != ST_ALARM) m_alarm_counting = 0;
    if (nxt == ST_TRIGGERED || nxt == ST_ALARM) m_led = 1;
    else if (nxt == ST_ARMED) begin
`ifdef STATUS_BLINK_EN
      m_led = (m_state == ST_ARMED) ? (m_led ^ one_hz_enable) : 1'b0;
`else
      m_led = 1;
`endif
    end else m_led = 0;
    m_since = go ? 0 : ((m_since < 100) ? m_since + 1 : 100);
    m_start = go;
    if (go) m_load = v;
    m_siren = (nxt == ST_ALARM);
    m_prev_door = any;
    m_state = nxt;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got state/start/load/siren/led=%h required %h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] dut_vec();
    return {fsm_state, start_timer, load_value, siren, status_led};
  endfunction

  function automatic logic [9:0] model_vec();
    return {m_state, m_start, m_load, m_siren, m_led};
  endfunction

  task automatic drive(input logic ign, dd, dp, rp, input logic [1:0] sel,
                       input logic [3:0] val, input logic ex, hz);
    @(negedge clk);
    ignition = ign; door_driver = dd; door_pass = dp; reprogram = rp;
    time_sel = sel; time_value = val; timer_expired = ex; one_hz_enable = hz;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic ign, dd, dp, rp;
    logic [1:0] sel;
    logic [3:0] val;
    logic ex;
    state_e st;
    logic start;
    logic [3:0] load;
    logic siren, led;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ign, dd, dp, rp, input logic [1:0] sel,
                     input logic [3:0] val, input logic ex, input state_e st,
                     input logic start, input logic [3:0] load, input logic sir, led);
    vec_t r;
    r.ign = ign; r.dd = dd; r.dp = dp; r.rp = rp; r.sel = sel; r.val = val; r.ex = ex;
    r.st = st; r.start = start; r.load = load; r.siren = sir; r.led = led;
    tbl.push_back(r);
  endtask

  initial begin
    rst_n = 0; ignition = 0; door_driver = 0; door_pass = 0; reprogram = 0;
    time_sel = 0; time_value = 0; one_hz_enable = 0; timer_expired = 0;
    model_reset();

    //  ign dd dp rp sel val ex  state              st load sir led
    add(0, 1, 0, 0, 0, 0, 0, ST_TRIGGERED,      1, 8,  0, 1);
    add(0, 1, 0, 0, 0, 0, 1, ST_TRIGGERED,      0, 8,  0, 1);
    add(0, 1, 0, 0, 0, 0, 1, ST_TRIGGERED,      0, 8,  0, 1);
    add(0, 1, 0, 0, 0, 0, 1, ST_ALARM,          0, 8,  1, 1);
    add(0, 1, 0, 0, 0, 0, 1, ST_ALARM,          0, 8,  1, 1);
    add(0, 0, 0, 0, 0, 0, 1, ST_ALARM,          1, 10, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, ST_ALARM,          0, 10, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, ST_ALARM,          0, 10, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, ST_ARMED,          0, 10, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, ST_DIS_IGN,        0, 10, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, ST_DIS_WAIT_OPEN,  0, 10, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, ST_DIS_WAIT_CLOSE, 0, 10, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, ST_ARM_DELAY,      1, 6,  0, 0);
    add(0, 0, 1, 0, 0, 0, 0, ST_DIS_WAIT_CLOSE, 0, 6,  0, 0);
    add(0, 0, 0, 0, 0, 0, 0, ST_ARM_DELAY,      1, 6,  0, 0);
    add(0, 0, 0, 0, 0, 0, 1, ST_ARM_DELAY,      0, 6,  0, 0);
    add(0, 0, 0, 0, 0, 0, 0, ST_ARM_DELAY,      0, 6,  0, 0);
    add(0, 0, 0, 0, 0, 0, 1, ST_ARMED,          0, 6,  0, 1);
    add(0, 0, 0, 1, 2, 3, 0, ST_ARMED,          0, 6,  0, 1);
    add(0, 0, 1, 0, 0, 0, 0, ST_TRIGGERED,      1, 3,  0, 1);
    add(0, 1, 1, 0, 0, 0, 0, ST_TRIGGERED,      0, 3,  0, 1);
    add(0, 1, 0, 0, 0, 0, 0, ST_TRIGGERED,      0, 3,  0, 1);
    add(0, 1, 0, 0, 0, 0, 1, ST_ALARM,          0, 3,  1, 1);
    add(0, 1, 0, 1, 3, 4, 0, ST_ARMED,          0, 3,  0, 1);
    add(0, 1, 1, 0, 0, 0, 0, ST_TRIGGERED,      1, 8,  0, 1);
    add(0, 0, 0, 1, 0, 0, 0, ST_ARMED,          0, 8,  0, 1);
    add(1, 0, 0, 0, 0, 0, 0, ST_DIS_IGN,        0, 8,  0, 0);
    add(0, 0, 0, 0, 0, 0, 0, ST_DIS_WAIT_OPEN,  0, 8,  0, 0);
    add(0, 1, 0, 0, 0, 0, 0, ST_DIS_WAIT_CLOSE, 0, 8,  0, 0);
    add(0, 0, 0, 0, 0, 0, 0, ST_ARM_DELAY,      1, 0,  0, 0);
    add(1, 1, 0, 0, 0, 0, 0, ST_DIS_IGN,        0, 0,  0, 0);

    repeat (2) @(posedge clk);
    #1 check("reset", dut_vec(), {ST_ARMED, 1'b0, 4'd0, 1'b0, 1'b0});
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      logic exp_led;
      drive(tbl[i].ign, tbl[i].dd, tbl[i].dp, tbl[i].rp, tbl[i].sel, tbl[i].val, tbl[i].ex, 1'b0);
      exp_led = tbl[i].led;
`ifdef STATUS_BLINK_EN
      exp_led = m_led;
`endif
      check($sformatf("vec%0d", i), dut_vec(),
            {tbl[i].st, tbl[i].start, tbl[i].load, tbl[i].siren, exp_led});
    end

    // Reset in the middle of an arm-delay countdown.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("arm_delay_start", dut_vec(), {ST_ARM_DELAY, 1'b1, 4'd0, 1'b0, 1'b0});
    #2 rst_n = 0;
    #1 check("reset_mid_count", dut_vec(), {ST_ARMED, 1'b0, 4'd0, 1'b0, 1'b0});
    model_reset();
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      check("after_reset_idle", dut_vec(), model_vec());
    end

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(7) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
            ($urandom_range(39) == 0), 2'($urandom_range(3)), 4'($urandom_range(15)),
            ($urandom_range(2) == 0), ($urandom_range(3) == 0));
      check($sformatf("rand%0d", i), dut_vec(), model_vec());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
